wave_generator: RTL and testbench
=================================

# wave_generator

Parametrised periodic waveform source, the successor to the fixed 0..2^N-1 triangle counter. It generates triangle, rising-sawtooth, falling-sawtooth or square waves between programmable lower and upper bounds, with a programmable step size and update prescaler. It drives display/plotter coordinates and test-pattern channels in the etch-a-sketch datapath. Reset configuration reproduces the legacy full-range, step-1 triangle exactly.

## Interface
- N, 8, sample width
- PW, 16, prescaler width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock clk
- ena  in  1  advance enable; all state holds when low
- load  in  1  single-cycle pulse: latch mode/lo/hi/step/period into active config, restart wave
- mode  in  2  0 = triangle, 1 = saw up, 2 = saw down, 3 = square
- lo  in  N  lower bound (inclusive)
- hi  in  N  upper bound (inclusive)
- step  in  N  increment magnitude per update
- period  in  PW  an update occurs every period+1 enabled cycles
- out  out  N  current sample, registered
- dir  out  1  0 = counting up, 1 = counting down (triangle state; 0 in other modes)
- wrap  out  1  one-cycle pulse on turnaround or wraparound
- cfg_err  out  1  active config invalid (lo > hi or step == 0); updates suppressed

## Operation
- Active config registers: mode_r, lo_r, hi_r, step_r, period_r. Reset values: triangle, 0, 2^N-1, 1, 0.
- Reset values of outputs and state: out=0, dir=0, wrap=0, cfg_err=0, pcnt=0.
- Priority: rst > load > update.
- load: latch the inputs, out<=lo, dir<=0, pcnt<=0, wrap<=0, cfg_err<=(lo>hi)|(step==0). Independent of ena.
- Prescaler: when ena=1 and cfg_err=0, an update fires if pcnt==period_r, and pcnt<=0; otherwise pcnt<=pcnt+1. When ena=0, pcnt holds.
- Saturating arithmetic is computed in N+1 bits, so no intermediate overflow occurs:
  - up(x) = min(x+step_r, hi_r)
  - dn(x) = (x-lo_r >= step_r) ? x-step_r : lo_r
- Update rules:
  - Triangle, dir=0: if out==hi_r, then out<=dn(out), dir<=1, wrap; else out<=up(out).
  - Triangle, dir=1: if out==lo_r, then out<=up(out), dir<=0, wrap; else out<=dn(out).
  - Saw up: if out==hi_r, then out<=lo_r, wrap; else out<=up(out).
  - Saw down: if out==lo_r, then out<=hi_r, wrap; else out<=dn(out).
  - Square: if out==lo_r, then out<=hi_r; else out<=lo_r, wrap.
- Each bound is reached exactly once per turnaround; a value is never repeated at a turn.
- lo_r==hi_r: out stays at lo_r and wrap pulses on every update.
- wrap is 0 on every cycle without an update.
- Config inputs are ignored except on the load cycle.
- cfg_err=1: out, dir and pcnt are frozen until the next valid load or rst.

## Timing
- Single clock domain; all outputs registered; no combinational input-to-output path.
- An update decided in cycle t appears on out/dir/wrap after edge t+1.
- wrap is high for exactly the one cycle in which out shows the first post-turn value.
- load at edge t: out=lo from t+1, cfg_err valid from t+1. The first update occurs after period+1 enabled cycles.
- Default config, ena held high: out changes every cycle; full triangle period is 2·(2^N-1) cycles.
- rst mid-wave: state returns to defaults on the next edge, discarding any load config.

## Test plan
- Reset, ena=1 held, N=8: out sequence is 0,1,…,255,254,…,1,0,1. wrap is high with out=254 and with out=1. dir=1 from out=254 through out=0.
- ena toggled 1,0,0,1 mid-ramp from out=5: out is 6,6,6,7. pcnt and wrap stay quiet while ena is low.
- load triangle lo=10 hi=20 step=4 period=0: out is 10,14,18,20,16,12,10,14. wrap is high at 16 and at 14.
- load saw-up lo=0 hi=9 step=3 period=2, ena=1: out holds each value 3 cycles through 0,3,6,9,0. wrap is high on the first cycle of the return to 0. Square lo=3 hi=7: out is 3,7,3,7, with wrap on each 3 after the first.
- load lo=50 hi=40: cfg_err=1, out=50 frozen for 20 enabled cycles. Then load lo=40 hi=50 step=0: cfg_err stays 1. Then load step=5: cfg_err=0 and the waveform resumes from 40.
- load asserted in the same cycle as a pending update: the new lo wins. rst asserted with load: defaults win (out=0). Random config/ena soak against a reference model, checking lo_r ≤ out ≤ hi_r at all times.

Source files
------------

// File: rtl/wave_generator_if.sv
// wave_generator_if: control and sample bundle for wave_generator
//   master drives ena/load/mode/lo/hi/step/period and observes out/dir/wrap/cfg_err
//   slave is the generator side
interface wave_generator_if #(
   parameter int N  = 8,
   parameter int PW = 16
);
   logic          ena;
   logic          load;
   logic [1:0]    mode;
   logic [N-1:0]  lo;
   logic [N-1:0]  hi;
   logic [N-1:0]  step;
   logic [PW-1:0] period;
   logic [N-1:0]  out;
   logic          dir;
   logic          wrap;
   logic          cfg_err;
   modport master (output ena, load, mode, lo, hi, step, period, input out, dir, wrap, cfg_err);
   modport slave  (input ena, load, mode, lo, hi, step, period, output out, dir, wrap, cfg_err);
endinterface

// File: rtl/wave_generator.sv
// wave_generator: triangle / saw-up / saw-down / square source between programmable bounds
//   clk, rst    : clock, synchronous active-high reset
//   bus.ena     : advance enable (all state holds when low)
//   bus.load    : latch mode/lo/hi/step/period and restart at lo
//   bus.out     : registered sample, bus.dir: triangle direction (1 = down)
//   bus.wrap    : one-cycle pulse with the first post-turn sample
//   bus.cfg_err : active config invalid (lo > hi or step == 0), updates frozen
module wave_generator #(
   parameter int N  = 8,
   parameter int PW = 16
) (
   input  logic clk,
   input  logic rst,
   wave_generator_if.slave bus
);
   typedef enum logic [1:0] {M_TRI, M_SAW_UP, M_SAW_DN, M_SQUARE} mode_e;
   mode_e         mode_q, mode_d;
   logic [N-1:0]  lo_q, lo_d, hi_q, hi_d, step_q, step_d, out_q, out_d;
   logic [PW-1:0] period_q, period_d, pcnt_q, pcnt_d;
   logic          dir_q, dir_d, wrap_q, wrap_d, err_q, err_d;
   logic [N:0]    sum, gap;
   logic [N-1:0]  up, dn;
   logic          at_hi, at_lo, turn, fire;
   // Saturating moves are done one bit wider so x+step can never wrap.
   assign sum   = {1'b0, out_q} + {1'b0, step_q};
   assign gap   = {1'b0, out_q} - {1'b0, lo_q};
   assign up    = (sum > {1'b0, hi_q}) ? hi_q : sum[N-1:0];
   assign dn    = (gap >= {1'b0, step_q}) ? out_q - step_q : lo_q;
   assign at_hi = out_q == hi_q;
   assign at_lo = out_q == lo_q;
   assign turn  = dir_q ? at_lo : at_hi;
   assign fire  = bus.ena && !err_q && pcnt_q == period_q;
   always_comb begin
      mode_d   = mode_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      step_d   = step_q;
      period_d = period_q;
      out_d    = out_q;
      dir_d    = dir_q;
      pcnt_d   = pcnt_q;
      err_d    = err_q;
      wrap_d   = 1'b0;
      if (bus.load) begin
         mode_d   = mode_e'(bus.mode);
         lo_d     = bus.lo;
         hi_d     = bus.hi;
         step_d   = bus.step;
         period_d = bus.period;
         out_d    = bus.lo;
         dir_d    = 1'b0;
         pcnt_d   = '0;
         err_d    = (bus.lo > bus.hi) || (bus.step == '0);
      end else if (bus.ena && !err_q) begin
         pcnt_d = fire ? '0 : pcnt_q + 1'b1;
         if (fire) begin
            case (mode_q)
               // A turn moves straight off the bound so no value repeats at the peak.
               M_TRI: begin
                  out_d  = (dir_q ^ turn) ? dn : up;
                  dir_d  = dir_q ^ turn;
                  wrap_d = turn;
               end
               M_SAW_UP: begin
                  out_d  = at_hi ? lo_q : up;
                  wrap_d = at_hi;
               end
               M_SAW_DN: begin
                  out_d  = at_lo ? hi_q : dn;
                  wrap_d = at_lo;
               end
               // Degenerate lo==hi still pulses wrap on every update.
               M_SQUARE: begin
                  out_d  = at_lo ? hi_q : lo_q;
                  wrap_d = !at_lo || at_hi;
               end
            endcase
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q   <= M_TRI;
         lo_q     <= '0;
         hi_q     <= '1;
         step_q   <= N'(1);
         period_q <= '0;
         out_q    <= '0;
         dir_q    <= 1'b0;
         pcnt_q   <= '0;
         wrap_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         step_q   <= step_d;
         period_q <= period_d;
         out_q    <= out_d;
         dir_q    <= dir_d;
         pcnt_q   <= pcnt_d;
         wrap_q   <= wrap_d;
         err_q    <= err_d;
      end
   end
   assign bus.out     = out_q;
   assign bus.dir     = dir_q;
   assign bus.wrap    = wrap_q;
   assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_wave_generator.sv
// tb_wave_generator: scoreboard bench for wave_generator (directed scenarios plus model soak)
module tb_wave_generator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   typedef struct packed {logic [7:0] o; logic d; logic w; logic e;} exp_t;
   exp_t sb[$];
   exp_t x, g;
   wave_generator_if #(.N(8), .PW(16)) bus();
   wave_generator #(.N(8), .PW(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic exp(input int o, input int d, input int w, input int e);
      sb.push_back({8'(o), 1'(d), 1'(w), 1'(e)});
   endtask
   task automatic set_cfg(input int m, input int l, input int h, input int s, input int p);
      bus.mode   = 2'(m);
      bus.lo     = 8'(l);
      bus.hi     = 8'(h);
      bus.step   = 8'(s);
      bus.period = 16'(p);
      bus.load   = 1'b1;
   endtask
   task automatic test_reset;
      rst = 1'b1;
      bus.ena = 1'b1;
      bus.load = 1'b0;
      exp(0, 0, 0, 0);
      exp(0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         tick;
         x = sb.pop_front();
         g = {bus.out, bus.dir, bus.wrap, bus.cfg_err};
         checks++;
         if (g !== x) begin
            errors++;
            $display("FAIL reset[%0d]: got out=%0d dir=%b wrap=%b cfg_err=%b, expected out=%0d dir=%b wrap=%b cfg_err=%b", i, g.o, g.d, g.w, g.e, x.o, x.d, x.w, x.e);
         end
      end
      rst = 1'b0;
      bus.ena = 1'b0;
   endtask
   task automatic test_legacy_triangle;
      int n;
      for (int v = 1; v <= 255; v++) exp(v, 0, 0, 0);
      for (int v = 254; v >= 0; v--) exp(v, 1, v == 254, 0);
      exp(1, 0, 1, 0);
      n = sb.size();
      bus.ena = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick;
         x = sb.pop_front();
         g = {bus.out, bus.dir, bus.wrap, bus.cfg_err};
         checks++;
         if (g !== x) begin
            errors++;
            $display("FAIL legacy[%0d]: got out=%0d dir=%b wrap=%b cfg_err=%b, expected out=%0d dir=%b wrap=%b cfg_err=%b", i, g.o, g.d, g.w, g.e, x.o, x.d, x.w, x.e);
         end
      end
      bus.ena = 1'b0;
   endtask
   task automatic test_ena_hold;
      int en[10] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 1};
      int ov[10] = '{0, 1, 2, 3, 4, 5, 6, 6, 6, 7};
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.ena = en[i][0];
         exp(ov[i], 0, 0, 0);
         tick;
         rst = 1'b0;
         x = sb.pop_front();
         g = {bus.out, bus.dir, bus.wrap, bus.cfg_err};
         checks++;
         if (g !== x) begin
            errors++;
            $display("FAIL ena_hold[%0d]: got out=%0d dir=%b wrap=%b cfg_err=%b, expected out=%0d dir=%b wrap=%b cfg_err=%b", i, g.o, g.d, g.w, g.e, x.o, x.d, x.w, x.e);
         end
      end
   endtask
   task automatic test_bounded_triangle;
      int n;
      bus.ena = 1'b1;
      set_cfg(0, 10, 20, 4, 0);
      exp(10, 0, 0, 0); exp(14, 0, 0, 0); exp(18, 0, 0, 0); exp(20, 0, 0, 0);
      exp(16, 1, 1, 0); exp(12, 1, 0, 0); exp(10, 1, 0, 0); exp(14, 0, 1, 0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         tick;
         bus.load = 1'b0;
         x = sb.pop_front();
         g = {bus.out, bus.dir, bus.wrap, bus.cfg_err};
         checks++;
         if (g !== x) begin
            errors++;
            $display("FAIL tri_bounds[%0d]: got out=%0d dir=%b wrap=%b cfg_err=%b, expected out=%0d dir=%b wrap=%b cfg_err=%b", i, g.o, g.d, g.w, g.e, x.o, x.d, x.w, x.e);
         end
      end
   endtask
   task automatic test_saw_square;
      int n;
      bus.ena = 1'b1;
      set_cfg(1, 0, 9, 3, 2);
      for (int v = 0; v <= 9; v += 3) for (int k = 0; k < 3; k++) exp(v, 0, 0, 0);
      exp(0, 0, 1, 0); exp(0, 0, 0, 0); exp(0, 0, 0, 0); exp(3, 0, 0, 0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         tick;
         bus.load = 1'b0;
         x = sb.pop_front();
         g = {bus.out, bus.dir, bus.wrap, bus.cfg_err};
         checks++;
         if (g !== x) begin
            errors++;
            $display("FAIL saw_up[%0d]: got out=%0d dir=%b wrap=%b cfg_err=%b, expected out=%0d dir=%b wrap=%b cfg_err=%b", i, g.o, g.d, g.w, g.e, x.o, x.d, x.w, x.e);
         end
      end
      set_cfg(3, 3, 7, 1, 0);
      exp(3, 0, 0, 0); exp(7, 0, 0, 0); exp(3, 0, 1, 0); exp(7, 0, 0, 0); exp(3, 0, 1, 0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         tick;
         bus.load = 1'b0;
         x = sb.pop_front();
         g = {bus.out, bus.dir, bus.wrap, bus.cfg_err};
         checks++;
         if (g !== x) begin
            errors++;
            $display("FAIL square[%0d]: got out=%0d dir=%b wrap=%b cfg_err=%b, expected out=%0d dir=%b wrap=%b cfg_err=%b", i, g.o, g.d, g.w, g.e, x.o, x.d, x.w, x.e);
         end
      end
   endtask
   task automatic test_cfg_err;
      int n;
      bus.ena = 1'b1;
      for (int phase = 0; phase < 3; phase++) begin
         if (phase == 0) begin
            set_cfg(0, 50, 40, 1, 0);
            for (int k = 0; k < 21; k++) exp(50, 0, 0, 1);
         end else if (phase == 1) begin
            set_cfg(0, 40, 50, 0, 0);
            for (int k = 0; k < 4; k++) exp(40, 0, 0, 1);
         end else begin
            set_cfg(0, 40, 50, 5, 0);
            exp(40, 0, 0, 0); exp(45, 0, 0, 0); exp(50, 0, 0, 0);
            exp(45, 1, 1, 0); exp(40, 1, 0, 0); exp(45, 0, 1, 0);
         end
         n = sb.size();
         for (int i = 0; i < n; i++) begin
            tick;
            bus.load = 1'b0;
            x = sb.pop_front();
            g = {bus.out, bus.dir, bus.wrap, bus.cfg_err};
            checks++;
            if (g !== x) begin
               errors++;
               $display("FAIL cfg_err%0d[%0d]: got out=%0d dir=%b wrap=%b cfg_err=%b, expected out=%0d dir=%b wrap=%b cfg_err=%b", phase, i, g.o, g.d, g.w, g.e, x.o, x.d, x.w, x.e);
            end
         end
      end
   endtask
   task automatic test_priority;
      bus.ena = 1'b1;
      for (int i = 0; i < 11; i++) begin
         bus.load = 1'b0;
         rst = 1'b0;
         case (i)
            0: begin set_cfg(1, 0, 100, 1, 0); exp(0, 0, 0, 0); end
            1: exp(1, 0, 0, 0);
            2: exp(2, 0, 0, 0);
            3: begin set_cfg(0, 60, 80, 2, 0); exp(60, 0, 0, 0); end
            4: exp(62, 0, 0, 0);
            5: begin set_cfg(2, 5, 9, 1, 0); rst = 1'b1; exp(0, 0, 0, 0); end
            6: exp(1, 0, 0, 0);
            7: exp(2, 0, 0, 0);
            8: begin set_cfg(0, 9, 5, 1, 0); exp(9, 0, 0, 1); end
            9: begin rst = 1'b1; exp(0, 0, 0, 0); end
            default: exp(1, 0, 0, 0);
         endcase
         tick;
         x = sb.pop_front();
         g = {bus.out, bus.dir, bus.wrap, bus.cfg_err};
         checks++;
         if (g !== x) begin
            errors++;
            $display("FAIL priority[%0d]: got out=%0d dir=%b wrap=%b cfg_err=%b, expected out=%0d dir=%b wrap=%b cfg_err=%b", i, g.o, g.d, g.w, g.e, x.o, x.d, x.w, x.e);
         end
      end
      rst = 1'b0;
      bus.load = 1'b0;
   endtask
   task automatic test_soak;
      int m_mode, m_lo, m_hi, m_step, m_per, m_o, m_d, m_w, m_err, m_pcnt;
      int r_mode, r_lo, r_hi, r_step, r_per, u, dv;
      logic r_rst, r_load, r_ena;
      for (int i = 0; i < 3000; i++) begin
         r_rst  = (i == 0) || ($urandom_range(0, 199) == 0);
         r_load = $urandom_range(0, 24) == 0;
         r_ena  = $urandom_range(0, 3) != 0;
         r_mode = $urandom_range(0, 3);
         r_lo   = $urandom_range(0, 200);
         r_hi   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : r_lo + $urandom_range(0, 255 - r_lo);
         r_step = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60);
         r_per  = $urandom_range(0, 3);
         rst = r_rst;
         bus.ena = r_ena;
         bus.load = r_load;
         bus.mode = 2'(r_mode);
         bus.lo = 8'(r_lo);
         bus.hi = 8'(r_hi);
         bus.step = 8'(r_step);
         bus.period = 16'(r_per);
         m_w = 0;
         if (r_rst) begin
            m_mode = 0; m_lo = 0; m_hi = 255; m_step = 1; m_per = 0;
            m_o = 0; m_d = 0; m_err = 0; m_pcnt = 0;
         end else if (r_load) begin
            m_mode = r_mode; m_lo = r_lo; m_hi = r_hi; m_step = r_step; m_per = r_per;
            m_o = r_lo; m_d = 0; m_pcnt = 0;
            m_err = (r_lo > r_hi || r_step == 0) ? 1 : 0;
         end else if (r_ena && m_err == 0) begin
            if (m_pcnt != m_per) m_pcnt++;
            else begin
               m_pcnt = 0;
               u  = (m_o + m_step > m_hi) ? m_hi : m_o + m_step;
               dv = (m_o - m_lo >= m_step) ? m_o - m_step : m_lo;
               if (m_mode == 0) begin
                  if (m_d == 0 && m_o == m_hi) begin m_o = dv; m_d = 1; m_w = 1; end
                  else if (m_d == 0) m_o = u;
                  else if (m_o == m_lo) begin m_o = u; m_d = 0; m_w = 1; end
                  else m_o = dv;
               end else if (m_mode == 1) begin
                  if (m_o == m_hi) begin m_o = m_lo; m_w = 1; end else m_o = u;
               end else if (m_mode == 2) begin
                  if (m_o == m_lo) begin m_o = m_hi; m_w = 1; end else m_o = dv;
               end else begin
                  if (m_o == m_lo) begin m_o = m_hi; m_w = (m_lo == m_hi) ? 1 : 0; end
                  else begin m_o = m_lo; m_w = 1; end
               end
            end
         end
         exp(m_o, m_d, m_w, m_err);
         tick;
         x = sb.pop_front();
         g = {bus.out, bus.dir, bus.wrap, bus.cfg_err};
         checks++;
         if (g !== x) begin
            errors++;
            $display("FAIL soak[%0d]: got out=%0d dir=%b wrap=%b cfg_err=%b, expected out=%0d dir=%b wrap=%b cfg_err=%b", i, g.o, g.d, g.w, g.e, x.o, x.d, x.w, x.e);
         end
         if (m_err == 0) begin
            checks++;
            if (int'(bus.out) < m_lo || int'(bus.out) > m_hi) begin
               errors++;
               $display("FAIL soak_bounds[%0d]: got out=%0d, expected within %0d..%0d", i, bus.out, m_lo, m_hi);
            end
         end
      end
      rst = 1'b0;
      bus.load = 1'b0;
   endtask
   initial begin
      bus.ena = 1'b0;
      bus.load = 1'b0;
      bus.mode = 2'd0;
      bus.lo = 8'd0;
      bus.hi = 8'd0;
      bus.step = 8'd0;
      bus.period = 16'd0;
      test_reset;
      test_legacy_triangle;
      test_ena_hold;
      test_bounded_triangle;
      test_saw_square;
      test_cfg_err;
      test_priority;
      test_soak;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
